// File: rtl/pc_issue_pkg.sv
// Core-wide constants shared by the fetch PC issuer, instruction-memory stage and CP0.
package pc_issue_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO    = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI    = 32'h0000_4FFC;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Priority mux for the next fetch address and redirect-hold state.
module pc_next_sel
  import pc_issue_pkg::*;
(
  input  pc_state_e   state,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] pc,
  input  logic [31:0] pend_target,
  output logic [31:0] next_pc,
  output pc_state_e   next_state
);

  always_comb begin
    next_pc    = pc;
    next_state = state;
    if (exc_req) begin
      next_pc    = EXC_VECTOR;
      next_state = RUN;
    end else if (eret_req) begin
      next_pc    = epc;
      next_state = RUN;
    end else if (stall) begin
      // A stalled redirect is parked; a newer one overwrites the older.
      if (br_valid) next_state = PEND;
    end else if (state == PEND) begin
      // The parked redirect is older than any branch arriving now, so it wins.
      next_pc    = pend_target;
      next_state = RUN;
    end else if (br_valid) begin
      next_pc = br_target;
    end else begin
      next_pc = pc + 32'd4;
    end
  end

endmodule

// File: rtl/pc_issue.sv
// Fetch-address initiator: owns the PC and the held branch target.
module pc_issue
  import pc_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc32,
  output logic        redir_pend
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  pc_state_e   state_q, state_d;

  pc_next_sel u_next_sel (
    .state       (state_q),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pc          (pc_q),
    .pend_target (pend_target_q),
    .next_pc     (pc_d),
    .next_state  (state_d)
  );

  always_comb begin
    pend_target_d = pend_target_q;
    if (exc_req || eret_req)
      pend_target_d = '0;
    else if (stall && br_valid)
      pend_target_d = br_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= PC_RESET;
      pend_target_q <= '0;
      state_q       <= RUN;
    end else begin
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      state_q       <= state_d;
    end
  end

  assign pc32       = pc_q;
  assign redir_pend = (state_q == PEND);

endmodule

// File: tb/tb_pc_issue.sv
// Bench for pc_issue: directed test-plan sequence plus randomized traffic against a reference model.
module tb_pc_issue;
  import pc_issue_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] pc32;
  logic        redir_pend;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc = 32'h0;
  logic        m_pend = 1'b0;
  logic [31:0] m_tgt = 32'h0;

  always #5 clk = ~clk;

  pc_issue dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .pc32       (pc32),
    .redir_pend (redir_pend)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour of one rising edge, written directly from the redirect rules.
  task automatic model_edge();
    if (reset) begin
      m_pc = PC_RESET; m_pend = 1'b0; m_tgt = 32'h0;
    end else if (exc_req) begin
      m_pc = EXC_VECTOR; m_pend = 1'b0;
    end else if (eret_req) begin
      m_pc = epc; m_pend = 1'b0;
    end else if (stall) begin
      if (br_valid) begin
        m_pend = 1'b1; m_tgt = br_target;
      end
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 1'b0;
    end else if (br_valid) begin
      m_pc = br_target;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_pc32", pc32, m_pc);
    chk("model_redir_pend", {31'b0, redir_pend}, {31'b0, m_pend});
  endtask

  task automatic drive(input logic r, input logic s, input logic bv, input logic [31:0] bt,
                       input logic ex, input logic er, input logic [31:0] ep);
    reset = r; stall = s; br_valid = bv; br_target = bt;
    exc_req = ex; eret_req = er; epc = ep;
    step();
  endtask

  task automatic lit(input string name, input logic [31:0] exp_pc, input logic exp_pend);
    chk({name, "_pc32"}, pc32, exp_pc);
    chk({name, "_pend"}, {31'b0, redir_pend}, {31'b0, exp_pend});
  endtask

  initial begin
    #1;
    drive(1, 0, 0, 0, 0, 0, 0);            lit("reset", 32'h3000, 0);
    drive(0, 0, 0, 0, 0, 0, 0);            lit("adv1", 32'h3004, 0);
    drive(0, 0, 0, 0, 0, 0, 0);            lit("adv2", 32'h3008, 0);
    drive(0, 0, 0, 0, 0, 0, 0);            lit("adv3", 32'h300C, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h3008);     lit("eret_3008", 32'h3008, 0);
    drive(0, 0, 1, 32'h3100, 0, 0, 0);     lit("branch", 32'h3100, 0);
    drive(0, 0, 0, 0, 0, 0, 0);            lit("branch_adv", 32'h3104, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h3010);     lit("eret_3010", 32'h3010, 0);
    drive(0, 1, 1, 32'h3200, 0, 0, 0);     lit("stall_br", 32'h3010, 1);
    drive(0, 1, 0, 0, 0, 0, 0);            lit("stall2", 32'h3010, 1);
    drive(0, 1, 0, 0, 0, 0, 0);            lit("stall3", 32'h3010, 1);
    drive(0, 0, 0, 0, 0, 0, 0);            lit("release", 32'h3200, 0);
    drive(0, 1, 1, 32'h3300, 0, 0, 0);     lit("pend2", 32'h3200, 1);
    drive(0, 1, 0, 0, 1, 0, 0);            lit("exc_flush", 32'h4180, 0);
    drive(0, 0, 0, 0, 0, 0, 0);            lit("no_stale", 32'h4184, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h3040);     lit("exc_over_eret", 32'h4180, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h3040);     lit("eret", 32'h3040, 0);
    drive(0, 1, 1, 32'h3500, 0, 0, 0);     lit("pend_a", 32'h3040, 1);
    drive(0, 1, 1, 32'h3580, 0, 0, 0);     lit("pend_last", 32'h3040, 1);
    drive(0, 0, 1, 32'h3600, 0, 0, 0);     lit("older_wins", 32'h3580, 0);
    drive(0, 0, 1, 32'h3700, 1, 0, 0);     lit("exc_over_br", 32'h4180, 0);
    drive(0, 0, 1, 32'h3002, 0, 0, 0);     lit("misaligned", 32'h3002, 0);
    drive(0, 0, 0, 0, 0, 0, 0);            lit("misaligned_adv", 32'h3006, 0);
    drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC); lit("eret_top", 32'hFFFF_FFFC, 0);
    drive(0, 0, 0, 0, 0, 0, 0);            lit("wrap", 32'h0000_0000, 0);
    drive(0, 1, 1, 32'h3900, 0, 0, 0);     lit("pend_pre_rst", 32'h0000_0000, 1);
    drive(1, 1, 1, 32'h3A00, 1, 0, 0);     lit("reset_mid_pend", 32'h3000, 0);
    drive(0, 0, 0, 0, 0, 0, 0);            lit("post_reset", 32'h3004, 0);

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) < 2);
      stall     = ($urandom_range(0, 99) < 40);
      br_valid  = ($urandom_range(0, 99) < 30);
      br_target = {$urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF)} & 32'h0000_FFFF | 32'h3000;
      exc_req   = ($urandom_range(0, 99) < 4);
      eret_req  = ($urandom_range(0, 99) < 4);
      epc       = $urandom();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_issue.md
# pc_issue

Fetch-address initiator for the pipelined MIPS core: owns the program counter and drives the 32-bit fetch address `pc32` into the instruction-memory stage every cycle. It applies sequential advance, decode-stage branch/jump redirects, exception entry and `eret` return. It honours the pipeline `stall`, and holds a branch redirect that arrives during a stall until the stall releases. Range and alignment checking stays in the instruction-memory stage; this block issues addresses unchanged.

## Interface
- `PC_RESET`, 32'h0000_3000, PC value after reset
- `EXC_VECTOR`, 32'h0000_4180, exception/interrupt entry address

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  fetch/decode hold from hazard unit; PC must not advance
- `br_valid`  in  1  decode stage resolved a taken branch or jump this cycle
- `br_target`  in  32  redirect address, valid with `br_valid`
- `exc_req`  in  1  CP0 exception/interrupt accepted; flush and vector
- `eret_req`  in  1  `eret` committing; return to `epc`
- `epc`  in  32  CP0 EPC, valid with `eret_req`
- `pc32`  out  32  registered fetch address to instruction memory
- `redir_pend`  out  1  high while a stalled redirect is held (state PEND)

## Operation
- State machine, 2 states:
  - RUN: no held redirect.
  - PEND: redirect latched in `pend_target`.
- Next-PC priority, highest first:
  - `exc_req` -> `EXC_VECTOR`
  - `eret_req` -> `epc`
  - state PEND and `!stall` -> `pend_target`
  - `br_valid` and `!stall` -> `br_target`
  - `!stall` -> `pc32 + 4`
  - otherwise hold.
- `exc_req` and `eret_req` act even when `stall`=1, because they flush the pipeline.
- Both `exc_req` and `eret_req` force the state to RUN and discard any held redirect.
- `br_valid` with `stall`=1 in RUN: latch `br_target`, go to PEND, hold `pc32`.
- `br_valid` with `stall`=1 in PEND: overwrite `pend_target` (last wins), stay in PEND.
- PEND with `stall`=0: load `pend_target` into `pc32` and return to RUN.
  - A `br_valid` in that same cycle is ignored, because the held redirect is the older, authoritative one.
- Arithmetic: `pc32 + 4` is 32-bit modulo; 32'hFFFF_FFFC advances to 32'h0000_0000.
- No range clamp on any address.
- Misaligned or out-of-range targets pass through unchanged; instruction memory reports error code 4 for them.
- Reset values:
  - `pc32` = `PC_RESET`, `redir_pend` = 0, state RUN, `pend_target` = 0.
  - Reset overrides every other input in the same cycle.

## Timing
- `pc32` is registered. Any redirect, vector or advance decided in cycle n is visible on `pc32` in cycle n+1; latency is 1 cycle.
- Stall: `pc32` is stable for every cycle `stall` is high, except when `exc_req` or `eret_req` is asserted.
- A held redirect appears on `pc32` in the cycle after the first cycle in which `stall` is low.
- `redir_pend` rises in the cycle after the latching edge. It falls in the cycle after release or flush.
- Simultaneous events:
  - `exc_req` + `eret_req`: exception wins.
  - `exc_req` + `br_valid` with `stall`=0: vector wins and the branch is dropped.
- Reset mid-PEND: the next cycle shows state RUN, `pc32` = `PC_RESET`, `redir_pend` = 0.
- All inputs are sampled only at the rising edge. There are no combinational paths from inputs to outputs.

## Structure
- Shared core package holds:
  - `PC_RESET`
  - `EXC_VECTOR`
  - instruction-memory window bounds 32'h0000_3000 and 32'h0000_4FFC
  - state encoding `{RUN, PEND}`
- The package is shared with the instruction-memory stage and CP0.
- One combinational sub-module, `pc_next_sel`: the priority mux producing `next_pc` and `next_state`.
- The PC and `pend_target` registers stay in `pc_issue`.

## Test plan
- Reset, then 3 free cycles -> `pc32` = 3000, 3004, 3008, 300C.
- At `pc32`=3008, `br_valid`=1, `br_target`=3100, no stall -> next `pc32`=3100, then 3104.
- At `pc32`=3010:
  - `stall`=1 for 3 cycles with `br_valid`=1 (target 3200) in the first cycle -> `pc32` holds at 3010 and `redir_pend`=1.
  - `stall` drops -> `pc32`=3200 and `redir_pend`=0.
- During `stall`=1 with PEND held, assert `exc_req` -> next `pc32`=4180, `redir_pend`=0, and the held target is never issued.
- Same cycle `exc_req`=1, `eret_req`=1, `epc`=3040 -> `pc32`=4180. Next cycle `eret_req` only -> `pc32`=3040.
- `br_target`=3002 (misaligned) -> `pc32`=3002 then 3006, unchanged. Force `pc32`=FFFF_FFFC via `eret` -> next `pc32`=0000_0000.
